point_affine: RTL and testbench



---
 rtl/point_affine.sv | 175 +++++++++++++++++
 tb/tb_point_affine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/point_affine.sv
// ============================================================================
// Module   : point_affine
// Purpose  : Jacobian (X,Y,Z) to affine (X/Z^2, Y/Z^3) mod p with a Montgomery
//            multiplier and a binary extended-Euclid inverter.
// Option   : POINT_AFFINE_ZINV_OUT_EN adds z_inv / z_zero outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module point_affine #(
    parameter int LEN = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [LEN-1:0] p,
    input  logic [LEN-1:0] p_prime,
    input  logic [LEN-1:0] r2_mod_p,
    input  logic           enable,
    input  logic [LEN-1:0] x,
    input  logic [LEN-1:0] y,
    input  logic [LEN-1:0] z,
    output logic [LEN-1:0] rx,
    output logic [LEN-1:0] ry,
`ifdef POINT_AFFINE_ZINV_OUT_EN
    output logic [LEN-1:0] z_inv,
    output logic [0:0]     z_zero,
`endif
    output logic           done
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_INV  = 4'd2,
        S_M1   = 4'd3,
        S_M2   = 4'd4,
        S_M3   = 4'd5,
        S_M4   = 4'd6,
        S_M5   = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t         r_state, w_next;
    logic [LEN-1:0] r_p, r_pp, r_r2, r_x, r_y, r_z;
    logic [LEN-1:0] r_u, r_v, r_x1, r_x2, r_zi;
    logic [LEN-1:0] r_a, r_b, r_c;

    // Coefficient halving mod p: odd values get p added first (p is odd).
    function automatic logic [LEN-1:0] f_halve(input logic [LEN-1:0] c,
                                               input logic [LEN-1:0] m);
        logic [LEN:0] s;
        s = c[0] ? ({1'b0, c} + {1'b0, m}) : {1'b0, c};
        return LEN'(s >> 1);
    endfunction

    function automatic logic [LEN-1:0] f_submod(input logic [LEN-1:0] a,
                                                input logic [LEN-1:0] b,
                                                input logic [LEN-1:0] m);
        return (a >= b) ? (a - b) : (a - b + m);
    endfunction

    // Single shared Montgomery multiplier, operands chosen by state.
    logic [LEN-1:0]   w_mm_a, w_mm_b, w_m, w_mm;
    logic [2*LEN-1:0] w_t, w_mp;
    logic [2*LEN:0]   w_sum;
    logic [LEN:0]     w_uu;

    always_comb begin
        w_mm_a = '0;
        w_mm_b = '0;
        case (r_state)
            S_M1: begin w_mm_a = r_zi; w_mm_b = r_r2; end
            S_M2: begin w_mm_a = r_a;  w_mm_b = r_a;  end
            S_M3: begin w_mm_a = r_b;  w_mm_b = r_a;  end
            S_M4: begin w_mm_a = r_x;  w_mm_b = r_b;  end
            S_M5: begin w_mm_a = r_y;  w_mm_b = r_c;  end
            default: ;
        endcase
    end

    always_comb begin
        w_t   = (2*LEN)'(w_mm_a) * (2*LEN)'(w_mm_b);
        w_m   = w_t[LEN-1:0] * r_pp;
        w_mp  = (2*LEN)'(w_m) * (2*LEN)'(r_p);
        w_sum = {1'b0, w_t} + {1'b0, w_mp};
        w_uu  = (LEN+1)'(w_sum >> LEN);
        w_mm  = (w_uu >= {1'b0, r_p}) ? LEN'(w_uu - {1'b0, r_p}) : w_uu[LEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (enable) w_next = S_LOAD;
            // A zero Z has no inverse; skip straight to the products with zi = 0.
            S_LOAD: w_next = (z == '0) ? S_M1 : S_INV;
            S_INV:  if (r_u == LEN'(1) || r_v == LEN'(1)) w_next = S_M1;
            S_M1:   w_next = S_M2;
            S_M2:   w_next = S_M3;
            S_M3:   w_next = S_M4;
            S_M4:   w_next = S_M5;
            S_M5:   w_next = S_DONE;
            S_DONE: if (!enable) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p  <= '0; r_pp <= '0; r_r2 <= '0;
            r_x  <= '0; r_y  <= '0; r_z  <= '0;
            r_u  <= '0; r_v  <= '0; r_x1 <= '0; r_x2 <= '0; r_zi <= '0;
            r_a  <= '0; r_b  <= '0; r_c  <= '0;
            rx   <= '0; ry   <= '0;
`ifdef POINT_AFFINE_ZINV_OUT_EN
            z_inv  <= '0;
            z_zero <= '0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_p  <= p;   r_pp <= p_prime; r_r2 <= r2_mod_p;
                    r_x  <= x;   r_y  <= y;       r_z  <= z;
                    r_u  <= z;   r_v  <= p;
                    r_x1 <= LEN'(1);
                    r_x2 <= '0;
                    r_zi <= '0;
                end
                S_INV: begin
                    // Invariant: x1*z == u and x2*z == v (mod p).
                    // Odd-odd subtraction is fused with the halving that
                    // must follow, so every cycle shrinks u or v by a bit.
                    if (r_u == LEN'(1)) begin
                        r_zi <= r_x1;
                    end else if (r_v == LEN'(1)) begin
                        r_zi <= r_x2;
                    end else if (!r_u[0]) begin
                        r_u  <= r_u >> 1;
                        r_x1 <= f_halve(r_x1, r_p);
                    end else if (!r_v[0]) begin
                        r_v  <= r_v >> 1;
                        r_x2 <= f_halve(r_x2, r_p);
                    end else if (r_u >= r_v) begin
                        r_u  <= (r_u - r_v) >> 1;
                        r_x1 <= f_halve(f_submod(r_x1, r_x2, r_p), r_p);
                    end else begin
                        r_v  <= (r_v - r_u) >> 1;
                        r_x2 <= f_halve(f_submod(r_x2, r_x1, r_p), r_p);
                    end
                end
                S_M1: r_a <= w_mm;
                S_M2: r_b <= w_mm;
                S_M3: r_c <= w_mm;
                S_M4: rx  <= w_mm;
                S_M5: begin
                    ry <= w_mm;
`ifdef POINT_AFFINE_ZINV_OUT_EN
                    z_inv  <= r_zi;
                    z_zero <= (r_z == '0);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_point_affine.sv
// ============================================================================
// Module   : tb_point_affine
// Purpose  : Self-checking bench for point_affine against a Fermat-inverse
//            reference model and known P-256 vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_point_affine;

    localparam int LEN = 256;
    localparam logic [LEN-1:0] P   = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
    localparam logic [LEN-1:0] PP  = 256'hffffffff00000002000000000000000000000001000000000000000000000001;
    localparam logic [LEN-1:0] R2  = 256'h4fffffffdfffffffffffffffefffffffbffffffff0000000000000003;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [LEN-1:0] p = P, p_prime = PP, r2_mod_p = R2;
    logic [LEN-1:0] x, y, z;
    logic [LEN-1:0] rx, ry;
    logic           done;
`ifdef POINT_AFFINE_ZINV_OUT_EN
    logic [LEN-1:0] z_inv;
    logic [0:0]     z_zero;
`endif

    int checks = 0;
    int errors = 0;

    point_affine #(.LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .p(p), .p_prime(p_prime), .r2_mod_p(r2_mod_p),
        .enable(enable), .x(x), .y(y), .z(z), .rx(rx), .ry(ry),
`ifdef POINT_AFFINE_ZINV_OUT_EN
        .z_inv(z_inv), .z_zero(z_zero),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: plain modular arithmetic ----------------
    function automatic logic [LEN-1:0] mulmod(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        logic [2*LEN-1:0] t;
        t = {{LEN{1'b0}}, a} * {{LEN{1'b0}}, b};
        t = t % {{LEN{1'b0}}, P};
        return t[LEN-1:0];
    endfunction

    function automatic logic [LEN-1:0] powmod(input logic [LEN-1:0] b, input logic [LEN-1:0] e);
        logic [LEN-1:0] r;
        r = LEN'(1);
        for (int i = LEN - 1; i >= 0; i--) begin
            r = mulmod(r, r);
            if (e[i]) r = mulmod(r, b);
        end
        return r;
    endfunction

    task automatic model(input logic [LEN-1:0] xi, input logic [LEN-1:0] yi,
                         input logic [LEN-1:0] zi, output logic [LEN-1:0] erx,
                         output logic [LEN-1:0] ery, output logic [LEN-1:0] ezi);
        logic [LEN-1:0] zi2;
        ezi = (zi == '0) ? '0 : powmod(zi, P - LEN'(2));
        zi2 = mulmod(ezi, ezi);
        erx = mulmod(xi, zi2);
        ery = mulmod(yi, mulmod(zi2, ezi));
    endtask

    function automatic logic [LEN-1:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [LEN-1:0] got, input logic [LEN-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [LEN-1:0] erx,
                           input logic [LEN-1:0] ery, input logic [LEN-1:0] ezi,
                           input logic ezz);
        chk({tag, "/rx"}, rx, erx);
        chk({tag, "/ry"}, ry, ery);
`ifdef POINT_AFFINE_ZINV_OUT_EN
        chk({tag, "/z_inv"}, z_inv, ezi);
        chk({tag, "/z_zero"}, LEN'(z_zero), LEN'(ezz));
`else
        if (ezz && ezi != '0) $display("note %s: zero z with nonzero inverse", tag);
`endif
    endtask

    // Apply operands at a negedge and raise enable; operands are scrambled once
    // the DUT has had its load cycle.
    task automatic request(input logic [LEN-1:0] xi, input logic [LEN-1:0] yi,
                           input logic [LEN-1:0] zi);
        x = xi; y = yi; z = zi;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        x = rand256(); y = rand256(); z = rand256();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2 * LEN + 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/done"}, LEN'(done), LEN'(1));
    endtask

    task automatic release_req(input string tag);
        enable = 1'b0;
        @(negedge clk);
        chk({tag, "/done_fall"}, LEN'(done), LEN'(0));
        @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input logic [LEN-1:0] xi,
                           input logic [LEN-1:0] yi, input logic [LEN-1:0] zi,
                           input logic [LEN-1:0] erx, input logic [LEN-1:0] ery);
        logic [LEN-1:0] mrx, mry, mzi;
        model(xi, yi, zi, mrx, mry, mzi);
        request(xi, yi, zi);
        wait_done(tag);
        chk_out(tag, erx, ery, mzi, zi == '0);
        release_req(tag);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [LEN-1:0] X1  = 256'hdf2ed7f585082cda490918bc98af28beaf17ec90231bd1852080f842170616e5;
    localparam logic [LEN-1:0] Y1  = 256'h72b1a02d167748c88557e16644f86e67ed7e61c211db886040f3f244f90ee47e;
    localparam logic [LEN-1:0] Z1  = 256'h11daa925abd70d369195511da110d9d14985ec614a06e794b16a0fb66ecdd6e2;
    localparam logic [LEN-1:0] RX1 = 256'heb38c810652b534a266a884168da2a4c08cf143590755e93224453fbd45d5d2f;
    localparam logic [LEN-1:0] RY1 = 256'h76145e5c2851aa9b5261b72dd059b6a802f578773b9def27c1fd783e5507bee2;
    localparam logic [LEN-1:0] X2  = 256'h9a978f59acd1b5ad570e7d52dcfcde43804b42274f61ddcf1e7d848391d6c70f;
    localparam logic [LEN-1:0] Y2  = 256'h4126885e7f786af905338238e5346d5fe77fc46388668bd0fd59be3190d2f5d1;
    localparam logic [LEN-1:0] Z2  = 256'h9fc685c5fc34ff371dcfd694f81f3c2c579c66aed662bd9d976c80d06f7ea3ea;
    localparam logic [LEN-1:0] RX2 = 256'h7cf27b188d034f7e8a52380304b51ac3c08969e277f21b35a60b48fc47669978;
    localparam logic [LEN-1:0] RY2 = 256'h07775510db8ed040293d9ac69f7430dbba7dade63ce982299e04b79d227873d1;

    initial begin
        logic [LEN-1:0] mrx, mry, mzi, rxs, rys, rxi, ryi, rzi;

        // Reset state, with enable already high
        x = X1; y = Y1; z = Z1; enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset/done", LEN'(done), LEN'(0));
        chk("reset/rx", rx, '0);
        chk("reset/ry", ry, '0);

        // Scenario 1: release reset with enable held high
        model(X1, Y1, Z1, mrx, mry, mzi);
        rst_n = 1'b1;
        request(X1, Y1, Z1);
        wait_done("s1");
        chk_out("s1", RX1, RY1, mzi, 1'b0);
        repeat (3) @(negedge clk);
        chk("s1/hold_done", LEN'(done), LEN'(1));
        chk("s1/hold_rx", rx, RX1);

        // Scenario 2: enable low for two cycles, new request; old results held
        enable = 1'b0;
        @(negedge clk);
        chk("s2/idle_done", LEN'(done), LEN'(0));
        @(negedge clk);
        model(X2, Y2, Z2, mrx, mry, mzi);
        request(X2, Y2, Z2);
        chk("s2/prev_rx", rx, RX1);
        chk("s2/prev_ry", ry, RY1);
        wait_done("s2");
        chk_out("s2", RX2, RY2, mzi, 1'b0);
        release_req("s2");

        // Scenario 3: z = 1 passes x, y straight through
        run_vec("s3", LEN'(5), LEN'(7), LEN'(1), LEN'(5), LEN'(7));

        // Scenario 4: z = 0 yields the point at infinity as zeros
        run_vec("s4", X1, Y1, '0, '0, '0);

        // Randomized points against the model
        for (int k = 0; k < 5; k++) begin
            rxi = rand256() % P;
            ryi = rand256() % P;
            rzi = (k == 0) ? LEN'(2) : (k == 1) ? P - LEN'(1) : rand256() % P;
            model(rxi, ryi, rzi, mrx, mry, mzi);
            run_vec($sformatf("rnd%0d", k), rxi, ryi, rzi, mrx, mry);
        end

        // enable dropped mid-computation: done pulses once, then idle
        rxi = rand256() % P; ryi = rand256() % P; rzi = rand256() % P;
        model(rxi, ryi, rzi, mrx, mry, mzi);
        request(rxi, ryi, rzi);
        enable = 1'b0;
        wait_done("drop");
        chk_out("drop", mrx, mry, mzi, rzi == '0);
        rxs = mrx; rys = mry;
        @(negedge clk);
        chk("drop/pulse_end", LEN'(done), LEN'(0));
        repeat (3) @(negedge clk);
        chk("drop/stay_idle", LEN'(done), LEN'(0));
        chk("drop/keep_rx", rx, rxs);
        chk("drop/keep_ry", ry, rys);

        // Scenario 5: asynchronous reset in the middle of the inversion
        request(X1, Y1, Z1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("s5/done", LEN'(done), LEN'(0));
        chk("s5/rx", rx, '0);
        chk("s5/ry", ry, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec("s5/after", X2, Y2, Z2, RX2, RY2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
